// File: rtl/axi4_mem_responder.sv
// ---------------------------------------------------------------------------
// axi4_mem_responder
//
// AXI4 slave memory model for the core's io_mem master port. On-chip array
// of 2^MEM_WORDS_LOG2 64-bit words mapped at BASE_ADDR. There is one
// outstanding burst per direction. Bursts can be INCR, FIXED or WRAP.
// Narrow transfers and byte strobes are supported.
//
// Ports (AXI4 names):
//   clock, reset        : single clock, asynchronous active-high reset
//   aw_* / w_* / b_*    : write address, write data and write response
//                         channels. aw_lock, aw_cache, aw_prot and aw_qos
//                         are ignored.
//   ar_* / r_*          : read address and read data channels. ar_lock,
//                         ar_cache, ar_prot and ar_qos are ignored.
//
// Optional feature macro: AXI4_MEM_RESPONDER_WLAST_CHECK_EN
//   When it is defined, a w_last that disagrees with the beat counter forces
//   b_resp to SLVERR for that burst. Data is still written under the normal
//   address-time rules.
//
// Error response codes are evaluated once, at address accept. Erroneous
// bursts are handshaken for their full length. Their writes are dropped and
// their reads return zero.
// ---------------------------------------------------------------------------
module axi4_mem_responder #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 64,
    parameter int                    ID_WIDTH       = 8,
    parameter int                    MEM_WORDS_LOG2 = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h8000_0000
) (
    input  logic                    clock,
    input  logic                    reset,
    // write address channel
    input  logic                    aw_valid,
    output logic                    aw_ready,
    input  logic [ID_WIDTH-1:0]     aw_id,
    input  logic [ADDR_WIDTH-1:0]   aw_addr,
    input  logic [7:0]              aw_len,
    input  logic [2:0]              aw_size,
    input  logic [1:0]              aw_burst,
    input  logic                    aw_lock,
    input  logic [3:0]              aw_cache,
    input  logic [2:0]              aw_prot,
    input  logic [3:0]              aw_qos,
    // write data channel
    input  logic                    w_valid,
    output logic                    w_ready,
    input  logic [DATA_WIDTH-1:0]   w_data,
    input  logic [DATA_WIDTH/8-1:0] w_strb,
    input  logic                    w_last,
    // write response channel
    output logic                    b_valid,
    input  logic                    b_ready,
    output logic [ID_WIDTH-1:0]     b_id,
    output logic [1:0]              b_resp,
    // read address channel
    input  logic                    ar_valid,
    output logic                    ar_ready,
    input  logic [ID_WIDTH-1:0]     ar_id,
    input  logic [ADDR_WIDTH-1:0]   ar_addr,
    input  logic [7:0]              ar_len,
    input  logic [2:0]              ar_size,
    input  logic [1:0]              ar_burst,
    input  logic                    ar_lock,
    input  logic [3:0]              ar_cache,
    input  logic [2:0]              ar_prot,
    input  logic [3:0]              ar_qos,
    // read data channel
    output logic                    r_valid,
    input  logic                    r_ready,
    output logic [ID_WIDTH-1:0]     r_id,
    output logic [DATA_WIDTH-1:0]   r_data,
    output logic [1:0]              r_resp,
    output logic                    r_last
);

    localparam int         MEM_DEPTH   = 1 << MEM_WORDS_LOG2;
    localparam int         STRB_W      = DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wstate_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_e;

    // Error code for a request. Checks run in priority order: size, then
    // reserved burst type, then WRAP length, then the address window.
    function automatic logic [1:0] addr_err(
        input logic [ADDR_WIDTH-1:0] a,
        input logic [7:0]            len,
        input logic [2:0]            size,
        input logic [1:0]            burst
    );
        logic [ADDR_WIDTH-1:0] off;
        logic [1:0]            code;
        off = a - BASE_ADDR;
        if (size > 3'd3) begin
            code = RESP_SLVERR;
        end else if (burst == 2'd3) begin
            code = RESP_SLVERR;
        end else if ((burst == 2'd2) && !((len == 8'd1) || (len == 8'd3) ||
                                          (len == 8'd7) || (len == 8'd15))) begin
            code = RESP_SLVERR;
        end else if ((a < BASE_ADDR) || ((off >> (MEM_WORDS_LOG2 + 3)) != '0)) begin
            code = RESP_DECERR;
        end else begin
            code = RESP_OKAY;
        end
        return code;
    endfunction

    // Per-beat address advance. WRAP keeps the bits above the wrap block and
    // lets only the in-block offset roll over.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] a,
        input logic [7:0]            len,
        input logic [2:0]            size,
        input logic [1:0]            burst
    );
        logic [ADDR_WIDTH-1:0] inc;
        logic [ADDR_WIDTH-1:0] mask;
        logic [ADDR_WIDTH-1:0] res;
        inc  = a + (ADDR_WIDTH'(1) << size);
        mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        case (burst)
            2'd0:    res = a;
            2'd1:    res = inc;
            2'd2:    res = (a & ~mask) | (inc & mask);
            default: res = inc;
        endcase
        return res;
    endfunction

    // Array word index. Truncating the offset makes out-of-window INCR
    // bursts wrap modulo the array depth.
    function automatic logic [MEM_WORDS_LOG2-1:0] word_idx(
        input logic [ADDR_WIDTH-1:0] a
    );
        return MEM_WORDS_LOG2'((a - BASE_ADDR) >> 3'd3);
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [0:MEM_DEPTH-1];

    // ---------------- write side ----------------
    wstate_e               wstate_q;
    logic [ID_WIDTH-1:0]   wid_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [7:0]            wlen_q;
    logic [2:0]            wsize_q;
    logic [1:0]            wburst_q;
    logic [7:0]            wbeat_q;
    logic [1:0]            werr_q;
    logic                  wmis_q;
    logic                  aw_ready_q;
    logic                  w_ready_q;
    logic                  b_valid_q;
    logic [ID_WIDTH-1:0]   b_id_q;
    logic [1:0]            b_resp_q;

    logic                  aw_fire_s;
    logic                  w_fire_s;
    logic                  b_fire_s;
    logic                  wlast_bad_s;
    logic                  mem_we_s;
    logic [ADDR_WIDTH-1:0] waddr_d;
    logic                  unused_s;

    assign aw_fire_s = aw_valid & aw_ready_q;
    assign w_fire_s  = w_valid & w_ready_q;
    assign b_fire_s  = b_valid_q & b_ready;
    assign waddr_d   = next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
    assign mem_we_s  = w_fire_s && (werr_q == RESP_OKAY);

`ifdef AXI4_MEM_RESPONDER_WLAST_CHECK_EN
    assign wlast_bad_s = (w_last != (wbeat_q == wlen_q));
    assign unused_s    = ^{aw_lock, aw_cache, aw_prot, aw_qos,
                           ar_lock, ar_cache, ar_prot, ar_qos};
`else
    assign wlast_bad_s = 1'b0;
    assign unused_s    = ^{aw_lock, aw_cache, aw_prot, aw_qos,
                           ar_lock, ar_cache, ar_prot, ar_qos, w_last};
`endif

    // Write FSM: accept AW, count W beats, then present the B response
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wstate_q   <= W_IDLE;
            wid_q      <= '0;
            waddr_q    <= '0;
            wlen_q     <= 8'd0;
            wsize_q    <= 3'd0;
            wburst_q   <= 2'd0;
            wbeat_q    <= 8'd0;
            werr_q     <= RESP_OKAY;
            wmis_q     <= 1'b0;
            aw_ready_q <= 1'b1;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            b_id_q     <= '0;
            b_resp_q   <= RESP_OKAY;
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    if (aw_fire_s) begin
                        wid_q      <= aw_id;
                        waddr_q    <= aw_addr;
                        wlen_q     <= aw_len;
                        wsize_q    <= aw_size;
                        wburst_q   <= aw_burst;
                        wbeat_q    <= 8'd0;
                        werr_q     <= addr_err(aw_addr, aw_len, aw_size, aw_burst);
                        wmis_q     <= 1'b0;
                        aw_ready_q <= 1'b0;
                        w_ready_q  <= 1'b1;
                        wstate_q   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire_s) begin
                        waddr_q <= waddr_d;
                        wbeat_q <= wbeat_q + 8'd1;
                        if (wlast_bad_s) begin
                            wmis_q <= 1'b1;
                        end
                        if (wbeat_q == wlen_q) begin
                            w_ready_q <= 1'b0;
                            b_valid_q <= 1'b1;
                            b_id_q    <= wid_q;
                            // a w_last mismatch on this or an earlier beat overrides the code
                            b_resp_q  <= (wmis_q || wlast_bad_s) ? RESP_SLVERR : werr_q;
                            wstate_q  <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (b_fire_s) begin
                        b_valid_q  <= 1'b0;
                        aw_ready_q <= 1'b1;
                        wstate_q   <= W_IDLE;
                    end
                end
                default: begin
                    wstate_q   <= W_IDLE;
                    aw_ready_q <= 1'b1;
                    w_ready_q  <= 1'b0;
                    b_valid_q  <= 1'b0;
                end
            endcase
        end
    end

    // Byte-strobed array write, no reset on the storage
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (w_strb[b]) begin
                    mem_q[word_idx(waddr_q)][8*b +: 8] <= w_data[8*b +: 8];
                end
            end
        end
    end

    // ---------------- read side ----------------
    rstate_e               rstate_q;
    logic [ID_WIDTH-1:0]   rid_q;
    logic [ADDR_WIDTH-1:0] raddr_q;
    logic [7:0]            rlen_q;
    logic [2:0]            rsize_q;
    logic [1:0]            rburst_q;
    logic [7:0]            rbeat_q;
    logic                  rdone_q;
    logic [1:0]            rerr_q;
    logic                  ar_ready_q;
    logic                  r_valid_q;
    logic [ID_WIDTH-1:0]   r_id_q;
    logic [DATA_WIDTH-1:0] r_data_q;
    logic [1:0]            r_resp_q;
    logic                  r_last_q;

    logic                  ar_fire_s;
    logic                  r_fire_s;
    logic                  r_issue_s;
    logic [ADDR_WIDTH-1:0] raddr_d;

    assign ar_fire_s = ar_valid & ar_ready_q;
    assign r_fire_s  = r_valid_q & r_ready;
    // Reads are issued only when the output register is free or is being
    // drained this cycle. The register holds steady while the master stalls.
    assign r_issue_s = (rstate_q == R_DATA) && !rdone_q && (!r_valid_q || r_ready);
    assign raddr_d   = next_addr(raddr_q, rlen_q, rsize_q, rburst_q);

    // Read FSM with its single output register stage
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rstate_q   <= R_IDLE;
            rid_q      <= '0;
            raddr_q    <= '0;
            rlen_q     <= 8'd0;
            rsize_q    <= 3'd0;
            rburst_q   <= 2'd0;
            rbeat_q    <= 8'd0;
            rdone_q    <= 1'b0;
            rerr_q     <= RESP_OKAY;
            ar_ready_q <= 1'b1;
            r_valid_q  <= 1'b0;
            r_id_q     <= '0;
            r_data_q   <= '0;
            r_resp_q   <= RESP_OKAY;
            r_last_q   <= 1'b0;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    if (ar_fire_s) begin
                        rid_q      <= ar_id;
                        raddr_q    <= ar_addr;
                        rlen_q     <= ar_len;
                        rsize_q    <= ar_size;
                        rburst_q   <= ar_burst;
                        rbeat_q    <= 8'd0;
                        rdone_q    <= 1'b0;
                        rerr_q     <= addr_err(ar_addr, ar_len, ar_size, ar_burst);
                        ar_ready_q <= 1'b0;
                        rstate_q   <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_issue_s) begin
                        // nonblocking array access gives old data on a same-cycle write
                        r_valid_q <= 1'b1;
                        r_data_q  <= (rerr_q == RESP_OKAY) ? mem_q[word_idx(raddr_q)] : '0;
                        r_id_q    <= rid_q;
                        r_resp_q  <= rerr_q;
                        r_last_q  <= (rbeat_q == rlen_q);
                        raddr_q   <= raddr_d;
                        rbeat_q   <= rbeat_q + 8'd1;
                        if (rbeat_q == rlen_q) begin
                            rdone_q <= 1'b1;
                        end
                    end else if (r_fire_s) begin
                        r_valid_q <= 1'b0;
                        if (r_last_q) begin
                            r_last_q   <= 1'b0;
                            ar_ready_q <= 1'b1;
                            rstate_q   <= R_IDLE;
                        end
                    end
                end
                default: begin
                    rstate_q   <= R_IDLE;
                    ar_ready_q <= 1'b1;
                    r_valid_q  <= 1'b0;
                    r_last_q   <= 1'b0;
                end
            endcase
        end
    end

    assign aw_ready = aw_ready_q;
    assign w_ready  = w_ready_q;
    assign b_valid  = b_valid_q;
    assign b_id     = b_id_q;
    assign b_resp   = b_resp_q;
    assign ar_ready = ar_ready_q;
    assign r_valid  = r_valid_q;
    assign r_id     = r_id_q;
    assign r_data   = r_data_q;
    assign r_resp   = r_resp_q;
    assign r_last   = r_last_q;

endmodule
